// File: rtl/spi_load_pkg.sv
// spi_load_pkg: shared constants and types for the SPI flash-programming
// command sequencer.
//   - opcode values of the byte protocol
//   - FSM state encoding
//   - number of bytes per address/data field
package spi_load_pkg;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_ADDR = 8'h01;
   localparam logic [7:0] OP_DATA = 8'h02;
   localparam logic [7:0] OP_CLR  = 8'hFF;

   localparam int unsigned BYTE_CNT = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_WRITE
   } state_t;

endpackage

// File: rtl/spi_load_ctrl_if.sv
// spi_load_ctrl_if: byte-input and memory-write-port bundle of spi_load_ctrl.
//   i_byte / i_byte_valid      received SPI byte and its one-cycle strobe
//   o_mem_req / i_mem_gnt      write request / grant handshake
//   o_mem_addr / o_mem_wdata   write address and data, stable while requesting
//   o_busy / o_err / o_ovf     status: not idle, sticky error, sticky overflow
//   o_wr_count                 number of granted writes
// Modports: master = the sequencer, slave = byte source / memory side.
interface spi_load_ctrl_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
);
   logic [7:0]        i_byte;
   logic              i_byte_valid;
   logic              o_mem_req;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [DATA_W-1:0] o_mem_wdata;
   logic              i_mem_gnt;
   logic              o_busy;
   logic              o_err;
   logic              o_ovf;
   logic [CNT_W-1:0]  o_wr_count;

   modport master (
      input  i_byte, i_byte_valid, i_mem_gnt,
      output o_mem_req, o_mem_addr, o_mem_wdata, o_busy, o_err, o_ovf, o_wr_count
   );

   modport slave (
      output i_byte, i_byte_valid, i_mem_gnt,
      input  o_mem_req, o_mem_addr, o_mem_wdata, o_busy, o_err, o_ovf, o_wr_count
   );
endinterface

// File: rtl/spi_load_shift.sv
// spi_load_shift: 4-byte MSB-first shift assembler.
//   clk, rst  clock, asynchronous active-high reset
//   clr       restart the byte index (register contents are kept)
//   load      shift din in at the LSB end; older bytes move toward the MSB
//   din       byte to shift in
//   set       parallel overwrite of the register with set_val (wins over load)
//   value     assembled register
//   done      high with the load of the 4th byte (combinational)
module spi_load_shift
   import spi_load_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [7:0]   din,
   input  logic         set,
   input  logic [W-1:0] set_val,
   output logic [W-1:0] value,
   output logic         done
);
   logic [1:0] idx;

   assign done = load && (idx == 2'(BYTE_CNT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
         idx   <= '0;
      end else begin
         if (set)
            value <= set_val;
         else if (load)
            value <= W'({value, din});  // bytes above W are shifted out and lost
         if (clr)
            idx <= '0;
         else if (load)
            idx <= done ? '0 : idx + 2'd1;
      end
   end
endmodule

// File: rtl/spi_load_ctrl.sv
// spi_load_ctrl: byte-stream command sequencer between the SPI byte receiver
// and the shared memory write port.
//   Protocol: 0x01 + 4 address bytes, 0x02 + 4 data bytes (MSB first),
//   0x00 no-op, 0xFF clears the sticky flags, anything else flags an error.
//   Each complete, aligned data word after a valid address gives one req/gnt write.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   bus           spi_load_ctrl_if.master (byte input, memory port, status)
// Build option: SPI_LOAD_AUTOINC_EN - when defined the address advances by 4
//   after every granted write; otherwise it is left unchanged.
module spi_load_ctrl
   import spi_load_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic            i_clk,
   input  logic            i_rst,
   spi_load_ctrl_if.master bus
);
   state_t             state;
   logic               addr_valid;
   logic               req;
   logic               busy;
   logic               err;
   logic               ovf;
   logic [CNT_W-1:0]   wr_count;

   logic [ADDR_W-1:0]  addr_val;
   logic [ADDR_W-1:0]  addr_next;
   logic [DATA_W-1:0]  data_val;
   logic               addr_load, addr_clr, addr_done, addr_set;
   logic               data_load, data_clr, data_done;
   logic               grant;

   assign grant     = (state == ST_WRITE) && bus.i_mem_gnt;
   assign addr_load = (state == ST_ADDR) && bus.i_byte_valid;
   assign data_load = (state == ST_DATA) && bus.i_byte_valid;
   assign addr_clr  = (state == ST_IDLE) && bus.i_byte_valid && (bus.i_byte == OP_ADDR);
   assign data_clr  = (state == ST_IDLE) && bus.i_byte_valid && (bus.i_byte == OP_DATA);

`ifdef SPI_LOAD_AUTOINC_EN
   assign addr_set  = grant;
   assign addr_next = addr_val + ADDR_W'(4);
`else
   assign addr_set  = 1'b0;
   assign addr_next = '0;
`endif

   spi_load_shift #(.W(ADDR_W)) u_addr (
      .clk     (i_clk),
      .rst     (i_rst),
      .clr     (addr_clr),
      .load    (addr_load),
      .din     (bus.i_byte),
      .set     (addr_set),
      .set_val (addr_next),
      .value   (addr_val),
      .done    (addr_done)
   );

   spi_load_shift #(.W(DATA_W)) u_data (
      .clk     (i_clk),
      .rst     (i_rst),
      .clr     (data_clr),
      .load    (data_load),
      .din     (bus.i_byte),
      .set     (1'b0),
      .set_val ('0),
      .value   (data_val),
      .done    (data_done)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         addr_valid <= 1'b0;
         req        <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
         ovf        <= 1'b0;
         wr_count   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.i_byte_valid) begin
                  case (bus.i_byte)
                     OP_NOP:  begin end
                     OP_ADDR: begin state <= ST_ADDR; busy <= 1'b1; end
                     OP_DATA: begin state <= ST_DATA; busy <= 1'b1; end
                     OP_CLR:  begin err <= 1'b0; ovf <= 1'b0; end
                     default: err <= 1'b1;
                  endcase
               end
            end
            ST_ADDR: begin
               if (addr_done) begin
                  addr_valid <= 1'b1;
                  state      <= ST_IDLE;
                  busy       <= 1'b0;
               end
            end
            ST_DATA: begin
               if (data_done) begin
                  if (addr_valid && (addr_val[1:0] == 2'b00)) begin
                     state <= ST_WRITE;
                     req   <= 1'b1;
                  end else begin
                     err   <= 1'b1;
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            ST_WRITE: begin
               // bytes are never accepted while a write is outstanding
               if (bus.i_byte_valid)
                  ovf <= 1'b1;
               if (grant) begin
                  req      <= 1'b0;
                  wr_count <= wr_count + 1'b1;
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               req   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_mem_req   = req;
   assign bus.o_mem_addr  = addr_val;
   assign bus.o_mem_wdata = data_val;
   assign bus.o_busy      = busy;
   assign bus.o_err       = err;
   assign bus.o_ovf       = ovf;
   assign bus.o_wr_count  = wr_count;
endmodule

// File: tb/tb_spi_load_ctrl.sv
// tb_spi_load_ctrl: directed table-driven bench for spi_load_ctrl plus
// hand-written sequences for stalled grants, address auto-increment and
// reset during a pending request.
module tb_spi_load_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_load_ctrl_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) bus ();

   spi_load_ctrl #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   // write monitor: a write completes at a clock edge with req & gnt high
   int          nwrites = 0;
   logic [31:0] wq_addr[$];
   logic [31:0] wq_data[$];
   always @(negedge clk) begin
      if (!rst && bus.o_mem_req && bus.i_mem_gnt) begin
         nwrites++;
         wq_addr.push_back(bus.o_mem_addr);
         wq_data.push_back(bus.o_mem_wdata);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.i_byte       = b;
      bus.i_byte_valid = 1'b1;
      tick();
      bus.i_byte_valid = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      bus.i_byte_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic        rst;
      logic        v;
      logic [7:0]  b;
      logic        gnt;
      logic        req;
      logic        busy;
      logic        err;
      logic        ovf;
      logic [15:0] cnt;
      logic        chk_bus;
      logic [31:0] addr;
      logic [31:0] data;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic v, input logic [7:0] b,
                               input logic req, input logic busy, input logic err,
                               input logic [15:0] cnt, input logic cb,
                               input logic [31:0] a, input logic [31:0] d);
      vec_t x;
      x.rst = r; x.v = v; x.b = b; x.gnt = 1'b1;
      x.req = req; x.busy = busy; x.err = err; x.ovf = 1'b0; x.cnt = cnt;
      x.chk_bus = cb; x.addr = a; x.data = d;
      return x;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int nw0;
      bus.i_byte       = 8'h00;
      bus.i_byte_valid = 1'b0;
      bus.i_mem_gnt    = 1'b1;

      //            rst v  byte   req busy err cnt chk addr          data
      // reset, then 01 40 00 00 00 02 DE AD BE EF with gnt tied high
      tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h01, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h40, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 1, 32'h4000_0000, 32'h0));
      tbl.push_back(mk(0, 1, 8'h02, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'hDE, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'hAD, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'hBE, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'hEF, 1, 1, 0, 0, 1, 32'h4000_0000, 32'hDEAD_BEEF));
      tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 1, 32'h4000_0000, 32'hDEAD_BEEF));
      tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 32'h0,         32'h0));
      // reset, data without address -> error; FF clears; bad opcode; no-op
      tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h02, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h11, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h22, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h33, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h44, 0, 0, 1, 0, 1, 32'h0,         32'h1122_3344));
      tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h07, 0, 0, 1, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h00, 0, 0, 1, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 0, 0, 32'h0,         32'h0));
      // misaligned address 0x2000_0002, then a data word -> error, no request
      tbl.push_back(mk(0, 1, 8'h01, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h20, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h02, 0, 0, 0, 0, 1, 32'h2000_0002, 32'h1122_3344));
      tbl.push_back(mk(0, 1, 8'h02, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h55, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h66, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h77, 0, 1, 0, 0, 0, 32'h0,         32'h0));
      tbl.push_back(mk(0, 1, 8'h88, 0, 0, 1, 0, 1, 32'h2000_0002, 32'h5566_7788));
      tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 32'h0,         32'h0));

      for (int i = 0; i < tbl.size(); i++) begin
         rst              = tbl[i].rst;
         bus.i_byte       = tbl[i].b;
         bus.i_byte_valid = tbl[i].v;
         bus.i_mem_gnt    = tbl[i].gnt;
         tick();
         chk($sformatf("v%0d_req", i),  bus.o_mem_req,  tbl[i].req);
         chk($sformatf("v%0d_busy", i), bus.o_busy,     tbl[i].busy);
         chk($sformatf("v%0d_err", i),  bus.o_err,      tbl[i].err);
         chk($sformatf("v%0d_ovf", i),  bus.o_ovf,      tbl[i].ovf);
         chk($sformatf("v%0d_cnt", i),  bus.o_wr_count, tbl[i].cnt);
         if (tbl[i].chk_bus) begin
            chk($sformatf("v%0d_addr", i), bus.o_mem_addr,  tbl[i].addr);
            chk($sformatf("v%0d_data", i), bus.o_mem_wdata, tbl[i].data);
         end
      end
      bus.i_byte_valid = 1'b0;
      rst = 1'b0;
      chk("table_writes", nwrites, 1);

      // grant withheld for 20 cycles, stray byte in cycle 5
      do_reset();
      bus.i_mem_gnt = 1'b0;
      send(8'h01); send(8'h40); send(8'h00); send(8'h00); send(8'h10);
      send(8'h02); send(8'hCA); send(8'hFE); send(8'hBA); send(8'hBE);
      nw0 = nwrites;
      for (int c = 0; c < 20; c++) begin
         bus.i_byte       = 8'h55;
         bus.i_byte_valid = (c == 5);
         tick();
         chk($sformatf("stall%0d_req", c),  bus.o_mem_req,   1'b1);
         chk($sformatf("stall%0d_addr", c), bus.o_mem_addr,  32'h4000_0010);
         chk($sformatf("stall%0d_data", c), bus.o_mem_wdata, 32'hCAFE_BABE);
         if (c == 5) chk("stall_ovf_set", bus.o_ovf, 1'b1);
      end
      bus.i_byte_valid = 1'b0;
      bus.i_mem_gnt    = 1'b1;
      tick();
      chk("stall_req_drop", bus.o_mem_req, 1'b0);
      chk("stall_cnt",      bus.o_wr_count, 16'd1);
      chk("stall_ovf_kept", bus.o_ovf, 1'b1);
      chk("stall_writes",   nwrites - nw0, 1);

      // three data commands after one address; byte in first gnt cycle dropped
      do_reset();
      bus.i_mem_gnt = 1'b1;
      wq_addr.delete();
      wq_data.delete();
      send(8'h01); send(8'h20); send(8'h00); send(8'h00); send(8'h00);
      for (int k = 0; k < 3; k++) begin
         send(8'h02);
         for (int j = 0; j < 4; j++) send(8'(8'h11 * (k + 1)));
         bus.i_byte       = 8'h01;
         bus.i_byte_valid = (k == 0);
         tick();
         bus.i_byte_valid = 1'b0;
         if (k == 0) begin
            chk("gnt_byte_ovf",     bus.o_ovf,  1'b1);
            chk("gnt_byte_dropped", bus.o_busy, 1'b0);
         end
      end
      chk("seq_cnt",    bus.o_wr_count, 16'd3);
      chk("seq_nwr",    wq_addr.size(), 3);
      for (int k = 0; k < 3 && k < wq_addr.size(); k++) begin
         logic [31:0] ea;
`ifdef SPI_LOAD_AUTOINC_EN
         ea = 32'h2000_0000 + 32'(4 * k);
`else
         ea = 32'h2000_0000;
`endif
         chk($sformatf("seq%0d_addr", k), wq_addr[k], ea);
         chk($sformatf("seq%0d_data", k), wq_data[k], {4{8'(8'h11 * (k + 1))}});
      end

      // asynchronous reset while a request is pending
      do_reset();
      bus.i_mem_gnt = 1'b0;
      send(8'h01); send(8'h40); send(8'h00); send(8'h00); send(8'h00);
      send(8'h02); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      chk("pend_req", bus.o_mem_req, 1'b1);
      nw0 = nwrites;
      #3 rst = 1'b1;
      #1 chk("async_rst_req", bus.o_mem_req, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_req",  bus.o_mem_req,   1'b0);
      chk("post_rst_busy", bus.o_busy,      1'b0);
      chk("post_rst_err",  bus.o_err,       1'b0);
      chk("post_rst_ovf",  bus.o_ovf,       1'b0);
      chk("post_rst_cnt",  bus.o_wr_count,  16'd0);
      chk("post_rst_addr", bus.o_mem_addr,  32'h0);
      chk("post_rst_data", bus.o_mem_wdata, 32'h0);
      bus.i_mem_gnt = 1'b1;
      send(8'h02); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
      tick();
      chk("post_rst_noaddr_err", bus.o_err,     1'b1);
      chk("post_rst_noaddr_req", bus.o_mem_req, 1'b0);
      chk("post_rst_nowrite",    nwrites - nw0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_load_ctrl.md
# spi_load_ctrl

Byte-stream command sequencer between the SPI slave byte receiver and the on-chip memory write port (instruction memory at 0x4000_0000, PIM buffer at 0x2000_0000). It decodes the flash-programming protocol (opcode 0x01 plus a 4-byte address, opcode 0x02 plus a 4-byte data word, both MSB first). For each complete data word it issues exactly one write request with a req/gnt handshake to the shared memory port. Error and overflow flags are sticky, and a write counter is provided for bring-up.

## Interface
- ADDR_W, 32, address width; address bytes beyond ADDR_W/8 are shifted out MSB-first and discarded.
- DATA_W, 32, write data width; fixed at 4 bytes per data command.
- CNT_W, 16, width of the write counter.

- i_clk  in  1  system clock; one clock domain.
- i_rst  in  1  reset, asynchronous, active-high.
- i_byte  in  8  received SPI byte.
- i_byte_valid  in  1  one-cycle strobe; i_byte is valid when high.
- o_mem_req  out  1  write request; held until granted.
- o_mem_addr  out  ADDR_W  write address; stable while o_mem_req is high.
- o_mem_wdata  out  DATA_W  write data; stable while o_mem_req is high.
- i_mem_gnt  in  1  grant; the write completes in any cycle with o_mem_req & i_mem_gnt.
- o_busy  out  1  high in every state except IDLE.
- o_err  out  1  sticky protocol error.
- o_ovf  out  1  sticky overflow; a byte was dropped during WRITE.
- o_wr_count  out  CNT_W  number of granted writes; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, ADDR, DATA, WRITE. The byte index counter runs 0..3.
- IDLE, on a valid byte:
  - 0x01 → ADDR, index cleared.
  - 0x02 → DATA, index cleared.
  - 0x00 → ignored (no-op).
  - 0xFF → clears o_err and o_ovf, stays in IDLE.
  - Any other value → sets o_err, stays in IDLE.
- ADDR: each valid byte shifts into the address register, MSB first. On the 4th byte, addr_valid is set and the FSM returns to IDLE.
- DATA: each valid byte shifts into the data register, MSB first. On the 4th byte:
  - If addr_valid=1 and addr[1:0]=0 → WRITE.
  - Otherwise → o_err is set, the word is dropped, and the FSM goes to IDLE.
- WRITE: o_mem_req is held high. On the gnt cycle:
  - o_wr_count increments.
  - The FSM goes to IDLE.
- A valid byte arriving in WRITE, including the gnt cycle, is dropped and sets o_ovf.
- addr_valid is cleared only by reset.
- A new 0x01 command overwrites the address. A partial address sequence leaves addr_valid at its prior value and the address register partially shifted.
- The data word is big-endian as received: the first byte lands in bits [31:24].

## Timing
- Reset values: o_mem_req=0, o_mem_addr=0, o_mem_wdata=0, o_busy=0, o_err=0, o_ovf=0, o_wr_count=0. The state returns to IDLE and addr_valid=0.
- Reset mid-operation aborts any pending request immediately, because reset is asynchronous. No write is performed for it.
- If the 4th data byte is valid in cycle N, o_mem_req is high from cycle N+1. It is a registered output with no combinational path from i_byte.
- o_mem_req falls in the cycle after the gnt. A gnt that is already high at N+1 gives a one-cycle request.
- i_mem_gnt is ignored whenever o_mem_req is low.
- The earliest next command byte accepted is in the cycle after the gnt.
- o_err, o_ovf and o_wr_count update one cycle after their causing event.

## Configuration
- SPI_LOAD_AUTOINC_EN:
  - Defined: after each granted write, the address increments by 4 and wraps at 2^ADDR_W. Consecutive 0x02 commands then fill sequential words without resending 0x01.
  - Undefined: the address is unchanged after a write, so repeated 0x02 commands rewrite the same word.

## Structure
- Package spi_load_pkg holds:
  - opcode localparams: OP_NOP=0x00, OP_ADDR=0x01, OP_DATA=0x02, OP_CLR=0xFF.
  - the state enum typedef.
  - the byte-count constant 4.
- One sub-module, spi_load_shift: a 4-byte MSB-first shift assembler with load/clear and done-on-4th-byte. It is instantiated twice, once for address and once for data.

## Test plan
- Bytes 01 40 00 00 00 02 DE AD BE EF with gnt tied high → exactly one req cycle, addr=0x4000_0000, wdata=0xDEADBEEF, o_wr_count=1, o_err=0.
- Bytes 02 11 22 33 44 sent before any address → no req, o_err=1. Then byte FF → o_err=0.
- Address 0x2000_0002 followed by a data command → no req, o_err=1 (misaligned).
- gnt held low for 20 cycles after a data word, with a byte 0x55 injected at cycle 5 → req stays high with stable addr and data, o_ovf=1, a single write on gnt.
- With SPI_LOAD_AUTOINC_EN: address 0x2000_0000, then three data commands → writes to 0x2000_0000, 0x2000_0004 and 0x2000_0008, o_wr_count=3. Without it, all three writes go to 0x2000_0000.
- Assert i_rst while req is pending → req=0 within the same cycle; after release all outputs are at reset values and addr_valid=0 (a data command alone gives o_err=1).
